// File: rtl/axi_10g_ethernet_0_sync_filter_bus.sv
// Multi-channel level synchroniser with a persistence filter and registered
// rise/fall event pulses for asynchronous status and control inputs.
module axi_10g_ethernet_0_sync_filter_bus #(
  parameter int                  C_NUM_CH        = 4,
  parameter int                  C_NUM_SYNC_REGS = 3,
  parameter logic [C_NUM_CH-1:0] C_RVAL          = {C_NUM_CH{1'b0}},
  parameter int                  C_FILT_CYCLES   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [C_NUM_CH-1:0] data_in,
  output logic [C_NUM_CH-1:0] data_out,
  output logic [C_NUM_CH-1:0] rise_pulse,
  output logic [C_NUM_CH-1:0] fall_pulse,
  output logic                any_change
);

  localparam int              CNT_W   = $clog2(C_FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_FILT_CYCLES - 1);

  logic [C_NUM_CH-1:0] sync_out;

  for (genvar gi = 0; gi < C_NUM_CH; gi++) begin : g_ch
    (* shreg_extract = "no", ASYNC_REG = "TRUE" *)
    logic [C_NUM_SYNC_REGS-1:0] sync_q;
    logic [C_NUM_SYNC_REGS-1:0] sync_d;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dout_q;
    logic             dout_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    always_comb begin
      sync_d = {sync_q[C_NUM_SYNC_REGS-2:0], data_in[gi]};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= {C_NUM_SYNC_REGS{C_RVAL[gi]}};
      end else begin
        sync_q <= sync_d;
      end
    end

    assign sync_out[gi] = sync_q[C_NUM_SYNC_REGS-1];

    // A differing level must survive C_FILT_CYCLES consecutive samples;
    // any agreement in between restarts the count.
    always_comb begin
      cnt_d  = cnt_q;
      dout_d = dout_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync_out[gi] == dout_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        dout_d = sync_out[gi];
        rise_d = sync_out[gi];
        fall_d = ~sync_out[gi];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        dout_q <= C_RVAL[gi];
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        dout_q <= dout_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign data_out[gi]   = dout_q;
    assign rise_pulse[gi] = rise_q;
    assign fall_pulse[gi] = fall_q;
  end

  assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_axi_10g_ethernet_0_sync_filter_bus.sv
// Bench for the synchroniser/filter bus: two configurations driven by shared
// stimulus and checked each cycle against a history-window reference model.
module tb_axi_10g_ethernet_0_sync_filter_bus;

  localparam int         NCH  = 4;
  localparam logic [3:0] RV   = 4'b0101;
  localparam int         N_A  = 3;
  localparam int         F_A  = 4;
  localparam int         N_B  = 2;
  localparam int         F_B  = 1;
  localparam int         HMAX = 8192;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] data_in;
  logic [NCH-1:0] data_out_a, rise_a, fall_a;
  logic [NCH-1:0] data_out_b, rise_b, fall_b;
  logic           any_a, any_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: data_in as sampled at each post-reset edge.
  logic [NCH-1:0] hist [HMAX];
  int             e;
  logic [NCH-1:0] dout_m [2];
  logic [NCH-1:0] rise_m [2];
  logic [NCH-1:0] fall_m [2];

  always #5 clk = ~clk;

  axi_10g_ethernet_0_sync_filter_bus #(
    .C_NUM_CH(NCH), .C_NUM_SYNC_REGS(N_A), .C_RVAL(RV), .C_FILT_CYCLES(F_A)
  ) u_dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a)
  );

  axi_10g_ethernet_0_sync_filter_bus #(
    .C_NUM_CH(NCH), .C_NUM_SYNC_REGS(N_B), .C_RVAL(RV), .C_FILT_CYCLES(F_B)
  ) u_dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .any_change(any_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Level seen at the end of an n-stage chain just before edge ee.
  function automatic logic obs_bit(input int n, input int ee, input int ch);
    if (ee - n >= 1) return hist[ee-n][ch];
    return RV[ch];
  endfunction

  task automatic model_reset();
    e = 0;
    for (int k = 0; k < 2; k++) begin
      dout_m[k] = RV;
      rise_m[k] = '0;
      fall_m[k] = '0;
    end
  endtask

  // Output follows a level only once the last F observed levels all agree on it.
  task automatic model_edge();
    int   n;
    int   f;
    logic v;
    bit   same;
    e++;
    hist[e] = data_in;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? N_A : N_B;
      f = (k == 0) ? F_A : F_B;
      rise_m[k] = '0;
      fall_m[k] = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        if (e - f + 1 >= 1) begin
          v    = obs_bit(n, e, ch);
          same = 1'b1;
          for (int j = 1; j < f; j++)
            if (obs_bit(n, e - j, ch) != v) same = 1'b0;
          if (same && (v != dout_m[k][ch])) begin
            dout_m[k][ch] = v;
            if (v) rise_m[k][ch] = 1'b1;
            else   fall_m[k][ch] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("A.data_out",   data_out_a, dout_m[0]);
    check("A.rise_pulse", rise_a,     rise_m[0]);
    check("A.fall_pulse", fall_a,     fall_m[0]);
    check("A.any_change", any_a,      |(rise_m[0] | fall_m[0]));
    check("B.data_out",   data_out_b, dout_m[1]);
    check("B.rise_pulse", rise_b,     rise_m[1]);
    check("B.fall_pulse", fall_b,     fall_m[1]);
    check("B.any_change", any_b,      |(rise_m[1] | fall_m[1]));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare_all();
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
  endtask

  logic [NCH-1:0] tmp;

  initial begin
    // Reset values with the clock running and inputs opposite to C_RVAL
    rst     = 1'b1;
    data_in = 4'b1010;
    model_reset();
    #1;
    compare_all();
    for (int c = 0; c < 5; c++) step();
    $display("[TB] reset hold: data_out_a=%b", data_out_a);

    // Single rise on channel 1
    #3;
    data_in = 4'b0101;
    rst     = 1'b0;
    for (int c = 0; c < 3; c++) step();
    data_in[1] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 6) check("s2.before", data_out_a, 4'b0101);
      if (c == 7) begin
        check("s2.data_out", data_out_a, 4'b0111);
        check("s2.rise",     rise_a,     4'b0010);
        check("s2.any",      any_a,      1'b1);
      end
      if (c == 8) check("s2.any_clear", any_a, 1'b0);
    end
    $display("[TB] single rise: data_out_a=%b", data_out_a);

    // 3-cycle glitch on channel 3 is rejected
    data_in[3] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 3) data_in[3] = 1'b0;
    end
    check("s3.short", data_out_a, 4'b0111);
    // 4-cycle level is accepted, then a 4-cycle low returns it
    data_in[3] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 4) data_in[3] = 1'b0;
      if (c == 7) begin
        check("s3.long",      data_out_a, 4'b1111);
        check("s3.long_rise", rise_a,     4'b1000);
      end
      if (c == 11) begin
        check("s3.fall_dout", data_out_a, 4'b0111);
        check("s3.fall",      fall_a,     4'b1000);
      end
    end
    $display("[TB] glitch rejection: data_out_a=%b", data_out_a);

    // Simultaneous rise and fall on different channels
    data_in = 4'b0101;
    for (int c = 0; c < 10; c++) step();
    data_in = 4'b0110;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 7) begin
        check("s4.data_out", data_out_a, 4'b0110);
        check("s4.rise",     rise_a,     4'b0010);
        check("s4.fall",     fall_a,     4'b0001);
        check("s4.any",      any_a,      1'b1);
      end
      if (c == 8) check("s4.any_clear", any_a, 1'b0);
    end
    $display("[TB] simultaneous events: data_out_a=%b", data_out_a);

    // Unfiltered config: a 1-cycle input pulse passes through as a 1-cycle output pulse
    data_in = 4'b0111;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) data_in = 4'b0110;
      if (c == 3) begin
        check("s6.b_dout_hi", data_out_b, 4'b0111);
        check("s6.b_rise",    rise_b,     4'b0001);
      end
      if (c == 4) begin
        check("s6.b_dout_lo", data_out_b, 4'b0110);
        check("s6.b_fall",    fall_b,     4'b0001);
      end
    end
    $display("[TB] no-filter pulse: data_out_b=%b", data_out_b);

    // Reset between edges 5 and 6 of a pending rise
    data_in = 4'b0101;
    for (int c = 0; c < 10; c++) step();
    data_in[1] = 1'b1;
    for (int c = 0; c < 5; c++) step();
    #2;
    assert_rst();
    check("s5.rst_dout", data_out_a, 4'b0101);
    step();
    step();
    #3;
    rst = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 6) check("s5.before", data_out_a, 4'b0101);
      if (c == 7) begin
        check("s5.data_out", data_out_a, 4'b0111);
        check("s5.rise",     rise_a,     4'b0010);
      end
    end
    $display("[TB] reset mid-filter: data_out_a=%b", data_out_a);

    // Randomised levels, sub-cycle glitches and occasional asynchronous resets
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        #($urandom_range(0, 2));
        assert_rst();
        for (int r = 0, nr = $urandom_range(1, 3); r < nr; r++) step();
        #2;
        data_in = NCH'($urandom_range(0, 15));
        rst     = 1'b0;
        $display("[TB] random reset at cycle %0d", c);
      end else begin
        for (int ch = 0; ch < NCH; ch++)
          if ($urandom_range(0, 4) == 0) data_in[ch] = ~data_in[ch];
        if ($urandom_range(0, 19) == 0) begin
          tmp     = data_in;
          data_in = data_in ^ NCH'($urandom_range(1, 15));
          #2;
          data_in = tmp;
        end
      end
      step();
    end
    $display("[TB] random phase done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_10g_ethernet_0_sync_filter_bus.md
# axi_10g_ethernet_0_sync_filter_bus

Multi-channel, parameterised level synchroniser for asynchronous status and control signals entering the `clk` domain of the 10G Ethernet subsystem, such as PHY link status, signal detect and external enables. Each channel has an N-stage ASYNC_REG chain with its own reset value. The chain is followed by a stability filter that propagates a level change only after it has persisted for a programmable number of cycles, plus registered rise/fall event pulses. It replaces ad-hoc instantiations of single-bit synchronisers with discrete edge-detect logic.

## Interface
Parameters:
- `C_NUM_CH`, 4, number of independent channels (≥1).
- `C_NUM_SYNC_REGS`, 3, synchroniser stages per channel (≥2).
- `C_RVAL`, {C_NUM_CH{1'b0}}, `C_NUM_CH`-bit vector; bit i is the reset value of every synchroniser stage and of `data_out[i]` for channel i.
- `C_FILT_CYCLES`, 4, consecutive cycles a changed synchronised level must persist before `data_out` follows (≥1; 1 = no filtering). Counter width is clog2(`C_FILT_CYCLES`+1).

Ports:
- `clk`, in, 1, destination clock.
- `rst`, in, 1, asynchronous, active-high reset.
- `data_in`, in, `C_NUM_CH`, asynchronous levels, one per channel.
- `data_out`, out, `C_NUM_CH`, synchronised, filtered levels.
- `rise_pulse`, out, `C_NUM_CH`, one-cycle pulse when `data_out[i]` goes 0→1.
- `fall_pulse`, out, `C_NUM_CH`, one-cycle pulse when `data_out[i]` goes 1→0.
- `any_change`, out, 1, OR-reduction of `rise_pulse | fall_pulse`; combinational from registered pulses, no added latency.

## Operation
- **Synchroniser chain (per channel i):** shift chain `sync[i][C_NUM_SYNC_REGS-1:0]`.
  - Attributes: shreg_extract="no", ASYNC_REG="TRUE".
  - Stage 0 samples `data_in[i]`.
  - `s[i]` is the last stage.
- **Filter (per channel i):** counter `cnt[i]` and `data_out[i]` register.
  - `s[i] == data_out[i]`: `cnt[i]` is cleared to 0.
  - `s[i] != data_out[i]` and `cnt[i] == C_FILT_CYCLES-1`: `data_out[i] <= s[i]` and `cnt[i] <= 0`.
  - `s[i] != data_out[i]` otherwise: `cnt[i] <= cnt[i]+1`.
  - A difference lasting fewer than `C_FILT_CYCLES` consecutive cycles is discarded: the counter restarts and `data_out` does not change.
- **Event pulses:**
  - `rise_pulse[i]` is registered and asserts on the same edge as a `data_out[i]` 0→1 update.
  - `fall_pulse[i]` likewise for 1→0.
  - Both deassert on the following edge unless another update occurs. Back-to-back updates on one channel are impossible for `C_FILT_CYCLES` ≥ 2.
- **Channel independence:** channels are fully independent. Simultaneous events on several channels produce simultaneous pulses, and `any_change` is high for that single cycle.
- **Reset values:**
  - Every synchroniser stage and `data_out[i]` are set to `C_RVAL[i]`.
  - `cnt` is set to 0.
  - `rise_pulse`, `fall_pulse` and `any_change` are set to 0.
- **Reset behaviour:**
  - Assertion takes effect immediately, without a clock edge, and aborts any in-progress filter count.
  - After release, an input differing from `C_RVAL` is treated as a real change and generates a pulse after full latency.

## Timing
- Let `data_in[i]` change, meeting setup, before edge 1 and then hold steady. Then:
  - `s[i]` changes at edge `C_NUM_SYNC_REGS`.
  - `data_out[i]` and its pulse assert at edge `C_NUM_SYNC_REGS + C_FILT_CYCLES`.
  - The pulse clears one edge later.
- Defaults (3 stages, filter 4): latency 7 edges.
- A glitch that is not captured by stage 0 has no effect.
- A metastable capture resolves to either level; latency varies by at most one cycle.
- Longest glitch that is rejected: `C_FILT_CYCLES-1` cycles of `s`.

## Test plan
Bench configuration unless stated otherwise: `C_NUM_CH`=4, `C_NUM_SYNC_REGS`=3, `C_FILT_CYCLES`=4, `C_RVAL`=4'b0101.

1. **Reset values:** hold `rst`=1, `data_in`=4'b1010, clock running → `data_out`=4'b0101, `rise_pulse`=`fall_pulse`=0, `any_change`=0 throughout.
2. **Single rise:** after reset, `data_in`=4'b0101, then `data_in[1]`→1 before edge 1, held → `data_out`=4'b0111 at edge 7; `rise_pulse`=4'b0010 and `any_change`=1 for exactly one cycle; `fall_pulse`=0.
3. **Glitch rejection:** `data_in[3]` high for 3 cycles → no change on `data_out` and no pulses. Repeat with 4 cycles → `data_out[3]`=1 at edge 7, `rise_pulse[3]` one cycle, then fall after a further 4-cycle low.
4. **Simultaneous events:** from 4'b0101, `data_in`→4'b0110 in one cycle → at edge 7, `data_out`=4'b0110, `rise_pulse`=4'b0010, `fall_pulse`=4'b0001, `any_change` high for one cycle.
5. **Reset mid-filter:** start the step of scenario 2 and assert `rst` asynchronously between edges 5 and 6 → `data_out` returns immediately to 4'b0101 with no pulse. After release with `data_in[1]` still 1 → update occurs 7 edges after the first post-reset edge.
6. **No filtering:** `C_FILT_CYCLES`=1, `C_NUM_SYNC_REGS`=2 → step latency 3 edges; a 1-cycle stable pulse on `data_in` propagates as a 1-cycle `data_out` pulse with rise then fall pulses on consecutive cycles.
